// File: rtl/layer_header_sequencer.sv
// layer_header_sequencer
// Walks the 32-entry layer header store on each frame start and presents each
// 128-bit header over a valid/ready handshake. Also runs a bulk layer clear
// through the store's active-low layer reset, and owns the controller-side
// layer/write-enable mux (host pass-through except while clearing).
// Optional feature macro: LAYER_SKIP_DISABLED_EN. When it is defined, layers
// whose header bit 0 (enable) is clear are examined but not presented.
module layer_header_sequencer (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_start,
    input  logic         clear_all_req,
    input  logic [4:0]   ctrl_layer_in,
    input  logic         ctrl_we_in,
    output logic [4:0]   hdr_rd_layer,
    input  logic [127:0] hdr_rd_data,
    output logic [4:0]   hdr_ctrl_layer,
    output logic         hdr_ctrl_we,
    output logic         hdr_clr_n,
    output logic         ctrl_stall,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   out_layer,
    output logic [127:0] out_header,
    output logic         frame_done,
    output logic         frame_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADDR,
        S_CAPTURE,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [4:0]     clr_idx_q, clr_idx_d;
    logic           pend_clr_q, pend_clr_d;
    logic           pend_scan_q, pend_scan_d;
    logic [4:0]     rd_layer_q, rd_layer_d;
    logic [4:0]     out_layer_q, out_layer_d;
    logic [127:0]   out_header_q, out_header_d;
    logic           scan_active;

    // A scan is in flight from ADDR through DONE; requests then are deferred or dropped.
    assign scan_active = (state_q == S_ADDR) || (state_q == S_CAPTURE) ||
                         (state_q == S_PRESENT) || (state_q == S_DONE);

    // State-derived outputs; the controller mux is only taken over while clearing.
    assign hdr_clr_n      = (state_q != S_CLEAR);
    assign ctrl_stall     = (state_q == S_CLEAR);
    assign hdr_ctrl_layer = (state_q == S_CLEAR) ? clr_idx_q : ctrl_layer_in;
    assign hdr_ctrl_we    = (state_q == S_CLEAR) ? 1'b0 : ctrl_we_in;
    assign hdr_rd_layer   = (state_q == S_ADDR) ? idx_q : rd_layer_q;
    assign out_valid      = (state_q == S_PRESENT);
    assign out_layer      = out_layer_q;
    assign out_header     = out_header_q;
    assign frame_done     = (state_q == S_DONE);
    assign frame_overrun  = scan_active && frame_start;

    // Next-state, index and pending-request logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        clr_idx_d    = clr_idx_q;
        pend_clr_d   = pend_clr_q;
        pend_scan_d  = pend_scan_q;
        rd_layer_d   = rd_layer_q;
        out_layer_d  = out_layer_q;
        out_header_d = out_header_q;

        // A clear requested mid-scan waits for the next IDLE.
        if (scan_active && clear_all_req) begin
            pend_clr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_clr_q || clear_all_req) begin
                    state_d    = S_CLEAR;
                    clr_idx_d  = 5'd0;
                    pend_clr_d = 1'b0;
                    if (frame_start) begin
                        pend_scan_d = 1'b1;
                    end
                end else if (pend_scan_q || frame_start) begin
                    state_d     = S_ADDR;
                    idx_d       = 5'd0;
                    pend_scan_d = 1'b0;
                end
            end
            S_CLEAR: begin
                if (frame_start) begin
                    pend_scan_d = 1'b1;
                end
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                rd_layer_d = idx_q;
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
`ifdef LAYER_SKIP_DISABLED_EN
                if (!hdr_rd_data[0]) begin
                    if (idx_q == 5'd31) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_ADDR;
                    end
                end else begin
                    out_header_d = hdr_rd_data;
                    out_layer_d  = idx_q;
                    state_d      = S_PRESENT;
                end
`else
                out_header_d = hdr_rd_data;
                out_layer_d  = idx_q;
                state_d      = S_PRESENT;
`endif
            end
            S_PRESENT: begin
                if (out_ready) begin
                    if (idx_q == 5'd31) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 5'd0;
            clr_idx_q    <= 5'd0;
            pend_clr_q   <= 1'b0;
            pend_scan_q  <= 1'b0;
            rd_layer_q   <= 5'd0;
            out_layer_q  <= 5'd0;
            out_header_q <= 128'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            clr_idx_q    <= clr_idx_d;
            pend_clr_q   <= pend_clr_d;
            pend_scan_q  <= pend_scan_d;
            rd_layer_q   <= rd_layer_d;
            out_layer_q  <= out_layer_d;
            out_header_q <= out_header_d;
        end
    end

endmodule

// File: tb/tb_layer_header_sequencer.sv
// Testbench for layer_header_sequencer: a behavioural header store plus a
// transaction-level model of expected handshake order, timing and contents.
module tb_layer_header_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_start;
    logic         clear_all_req;
    logic [4:0]   ctrl_layer_in;
    logic         ctrl_we_in;
    logic [4:0]   hdr_rd_layer;
    logic [127:0] hdr_rd_data;
    logic [4:0]   hdr_ctrl_layer;
    logic         hdr_ctrl_we;
    logic         hdr_clr_n;
    logic         ctrl_stall;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   out_layer;
    logic [127:0] out_header;
    logic         frame_done;
    logic         frame_overrun;

    logic [127:0] wdata;
    logic [127:0] store   [32];
    logic [127:0] exp_mem [32];

    int n_chk  = 0;
    int n_pass = 0;

    // Model state for the scan in progress.
    int m_cur, m_addr, m_valid, m_done;

    always #5 clk = ~clk;

    layer_header_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .clear_all_req  (clear_all_req),
        .ctrl_layer_in  (ctrl_layer_in),
        .ctrl_we_in     (ctrl_we_in),
        .hdr_rd_layer   (hdr_rd_layer),
        .hdr_rd_data    (hdr_rd_data),
        .hdr_ctrl_layer (hdr_ctrl_layer),
        .hdr_ctrl_we    (hdr_ctrl_we),
        .hdr_clr_n      (hdr_clr_n),
        .ctrl_stall     (ctrl_stall),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_layer      (out_layer),
        .out_header     (out_header),
        .frame_done     (frame_done),
        .frame_overrun  (frame_overrun)
    );

    // Header store: registered pipeline read, controller port with layer reset priority.
    always @(posedge clk) begin
        hdr_rd_data <= store[hdr_rd_layer];
        if (!hdr_clr_n) begin
            store[hdr_ctrl_layer] <= 128'd0;
        end else if (hdr_ctrl_we) begin
            store[hdr_ctrl_layer] <= wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Find the next layer to present starting from m_cur whose ADDR cycle is m_addr.
    task automatic advance();
        m_valid = -1;
        while (m_valid < 0 && m_done < 0) begin
`ifdef LAYER_SKIP_DISABLED_EN
            if (!exp_mem[m_cur][0]) begin
                if (m_cur == 31) begin
                    m_done = m_addr + 2;
                end else begin
                    m_cur  = m_cur + 1;
                    m_addr = m_addr + 2;
                end
            end else begin
                m_valid = m_addr + 2;
            end
`else
            m_valid = m_addr + 2;
`endif
        end
    endtask

    task automatic host_write(input int l, input logic [127:0] d);
        @(negedge clk);
        ctrl_layer_in = l[4:0];
        ctrl_we_in    = 1'b1;
        wdata         = d;
        @(posedge clk);
        #1;
        ctrl_we_in = 1'b0;
        exp_mem[l] = d;
    endtask

    // mode: 0 ready always high, 1 random ready, 2 ready low for 5 cycles on layer 4.
    task automatic run_op(input bit do_clear, input bit do_scan, input int mode, input int ovr_layer);
        int c;
        int end_c;
        int n_hs;
        bit injected;
        bit exp_v;
        @(negedge clk);
        frame_start   = do_scan;
        clear_all_req = do_clear;
        ctrl_we_in    = 1'b0;
        #1;
        check_eq("overrun_at_start", frame_overrun, 1'b0);
        @(posedge clk);
        #1;
        frame_start   = 1'b0;
        clear_all_req = 1'b0;
        if (do_clear) begin
            for (int l = 0; l < 32; l++) exp_mem[l] = 128'd0;
        end
        c        = 1;
        n_hs     = 0;
        injected = 1'b0;
        m_cur    = 0;
        m_addr   = do_clear ? 34 : 1;
        m_valid  = -1;
        m_done   = -1;
        if (do_scan) advance();
        end_c = do_scan ? -1 : 33;
        while (1) begin
            @(negedge clk);
            ctrl_layer_in = 5'($urandom);
            wdata         = {$urandom, $urandom, $urandom, $urandom};
            ctrl_we_in    = do_clear && (c <= 32);
            exp_v         = (m_valid >= 0) && (c >= m_valid);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = !(m_cur == 4 && exp_v && c < m_valid + 5);
            endcase
            if (ovr_layer >= 0 && !injected && exp_v && m_cur == ovr_layer) begin
                frame_start = 1'b1;
                injected    = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            #1;
            if (do_clear && c <= 32) begin
                check_eq("clr_n_low", hdr_clr_n, 1'b0);
                check_eq("stall_high", ctrl_stall, 1'b1);
                check_eq("ctrl_we_blocked", hdr_ctrl_we, 1'b0);
                check_eq("clr_layer", hdr_ctrl_layer, 128'(c - 1));
            end else begin
                check_eq("clr_n_high", hdr_clr_n, 1'b1);
                check_eq("stall_low", ctrl_stall, 1'b0);
                check_eq("ctrl_we_pass", hdr_ctrl_we, ctrl_we_in);
                check_eq("ctrl_layer_pass", hdr_ctrl_layer, ctrl_layer_in);
            end
            if (do_scan) begin
                check_eq("out_valid", out_valid, exp_v);
                check_eq("frame_overrun", frame_overrun, frame_start);
                check_eq("frame_done", frame_done, c == m_done);
                if (exp_v) begin
                    check_eq("out_layer", out_layer, 128'(m_cur));
                    check_eq("out_header", out_header, exp_mem[m_cur]);
                    if (out_ready) begin
                        n_hs++;
                        if (m_cur == 31) begin
                            m_valid = -1;
                            m_done  = c + 1;
                        end else begin
                            m_cur  = m_cur + 1;
                            m_addr = c + 1;
                            advance();
                        end
                    end
                end
                if (c == m_done) break;
            end else if (c == end_c) begin
                break;
            end
            if (c > 3000) begin
                check_eq("timeout", 1'b1, 1'b0);
                break;
            end
            @(posedge clk);
            c++;
        end
        @(negedge clk);
        frame_start = 1'b0;
        ctrl_we_in  = 1'b0;
        out_ready   = 1'b0;
        $display("op clear=%0d scan=%0d mode=%0d handshakes=%0d cycles=%0d", do_clear, do_scan, mode, n_hs, c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, out_valid, 1'b0);
        check_eq({tag, "_layer"}, out_layer, 5'd0);
        check_eq({tag, "_header"}, out_header, 128'd0);
        check_eq({tag, "_done"}, frame_done, 1'b0);
        check_eq({tag, "_overrun"}, frame_overrun, 1'b0);
        check_eq({tag, "_stall"}, ctrl_stall, 1'b0);
        check_eq({tag, "_rd_layer"}, hdr_rd_layer, 5'd0);
        check_eq({tag, "_clr_n"}, hdr_clr_n, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        frame_start   = 1'b0;
        clear_all_req = 1'b0;
        ctrl_layer_in = 5'd0;
        ctrl_we_in    = 1'b0;
        out_ready     = 1'b0;
        wdata         = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Headers are the layer index replicated across the word.
        for (int l = 0; l < 32; l++) host_write(l, {16{8'(l)}});
        run_op(1'b0, 1'b1, 0, -1);
        run_op(1'b0, 1'b1, 2, -1);

        for (int l = 0; l < 32; l++) host_write(l, {$urandom, $urandom, $urandom, $urandom});
        run_op(1'b0, 1'b1, 1, -1);

        run_op(1'b1, 1'b0, 0, -1);
        run_op(1'b0, 1'b1, 1, -1);

        for (int l = 0; l < 32; l++) host_write(l, {$urandom, $urandom, $urandom, $urandom});
        run_op(1'b1, 1'b1, 0, 10);

`ifdef LAYER_SKIP_DISABLED_EN
        for (int l = 0; l < 32; l++)
            host_write(l, {$urandom, $urandom, $urandom, $urandom[31:1], (l == 3 || l == 17)});
        run_op(1'b0, 1'b1, 1, -1);
        for (int l = 0; l < 32; l++) host_write(l, {$urandom, $urandom, $urandom, $urandom[31:1], 1'b0});
        run_op(1'b0, 1'b1, 0, -1);
`endif

        // Reset during a clear while layer 7 is addressed: layers 0..6 cleared, rest kept.
        for (int l = 0; l < 32; l++) host_write(l, {$urandom, $urandom, $urandom, $urandom, 1'b1});
        @(negedge clk);
        clear_all_req = 1'b1;
        @(posedge clk);
        #1;
        clear_all_req = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check_eq("clr_idx7_layer", hdr_ctrl_layer, 5'd7);
        check_eq("clr_idx7_clr_n", hdr_clr_n, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        for (int l = 0; l < 7; l++) exp_mem[l] = 128'd0;
        @(negedge clk);
        reset = 1'b0;
        $display("reset during clear at clr_idx=7");
        run_op(1'b0, 1'b1, 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
